// File: rtl/router_fsm_np_if.sv
// Router FSM handshake bundle: source/FIFO status toward the FSM, state decodes back.
interface router_fsm_np_if #(
   parameter int NUM_PORTS = 3,
   parameter int ADDR_W    = 2
);
   logic                 pkt_valid;
   logic [ADDR_W-1:0]    data_in;
   logic                 fifo_full;
   logic [NUM_PORTS-1:0] fifo_empty;
   logic [NUM_PORTS-1:0] soft_reset;
   logic                 parity_done;
   logic                 low_packet_valid;

   logic                 detect_add;
   logic                 lfd_state;
   logic                 ld_state;
   logic                 laf_state;
   logic                 full_state;
   logic                 rst_int_reg;
   logic                 write_enb_reg;
   logic                 busy;
   logic                 drop_state;
   logic                 wait_timeout;
   logic [ADDR_W-1:0]    dest_port;

   modport master (
      output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_packet_valid,
      input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
             write_enb_reg, busy, drop_state, wait_timeout, dest_port
   );

   modport slave (
      input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_packet_valid,
      output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
             write_enb_reg, busy, drop_state, wait_timeout, dest_port
   );
endinterface

// File: rtl/router_fsm_np.sv
// Router packet-control FSM: address decode, FIFO load sequencing, bounded wait
// for a busy destination, and discard of packets addressed to nonexistent ports.
module router_fsm_np #(
   parameter int NUM_PORTS    = 3,
   parameter int ADDR_W       = 2,
   parameter int WAIT_TIMEOUT = 255
) (
   input  logic           clock,
   input  logic           resetn,
   router_fsm_np_if.slave bus
);

   if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_np_range
      $error("router_fsm_np: NUM_PORTS must be in 2..8");
   end
   if ((1 << ADDR_W) < NUM_PORTS) begin : g_addr_range
      $error("router_fsm_np: 2**ADDR_W must be >= NUM_PORTS");
   end
   if (WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 65535) begin : g_wt_range
      $error("router_fsm_np: WAIT_TIMEOUT must be in 1..65535");
   end

   localparam int              SPAN     = 1 << ADDR_W;
   localparam logic [ADDR_W:0] NP_LIMIT = (ADDR_W+1)'(NUM_PORTS);
   localparam logic [15:0]     WT_LAST  = 16'(WAIT_TIMEOUT - 1);

   typedef enum logic [3:0] {
      DECODE_ADDRESS     = 4'd0,
      LOAD_FIRST_DATA    = 4'd1,
      LOAD_DATA          = 4'd2,
      WAIT_TILL_EMPTY    = 4'd3,
      LOAD_PARITY        = 4'd4,
      CHECK_PARITY_ERROR = 4'd5,
      FIFO_FULL_STATE    = 4'd6,
      LOAD_AFTER_FULL    = 4'd7,
      DROP_PACKET        = 4'd8
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] dest_q, dest_d;
   logic [15:0]       wcnt_q, wcnt_d;
   logic              expire;
   logic              addr_ok;
   logic [SPAN-1:0]   empty_ext;
   logic [SPAN-1:0]   srst_ext;

   // Zero-pad per-port flags to the full address space so an out-of-range
   // latched address (only possible while dropping) reads as empty=0, soft_reset=0.
   always_comb begin
      empty_ext                = '0;
      srst_ext                 = '0;
      empty_ext[NUM_PORTS-1:0] = bus.fifo_empty;
      srst_ext[NUM_PORTS-1:0]  = bus.soft_reset;
      addr_ok                  = ({1'b0, bus.data_in} < NP_LIMIT);
   end

   // Next-state, destination latch and wait-counter logic.
   always_comb begin
      state_d = state_q;
      dest_d  = dest_q;
      wcnt_d  = '0;
      expire  = 1'b0;
      unique case (state_q)
         DECODE_ADDRESS: begin
            if (bus.pkt_valid) begin
               dest_d = bus.data_in;
               if (!addr_ok)                      state_d = DROP_PACKET;
               else if (empty_ext[bus.data_in])   state_d = LOAD_FIRST_DATA;
               else                               state_d = WAIT_TILL_EMPTY;
            end
         end
         LOAD_FIRST_DATA:    state_d = LOAD_DATA;
         LOAD_DATA: begin
            if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
            else if (!bus.pkt_valid) state_d = LOAD_PARITY;
         end
         WAIT_TILL_EMPTY: begin
            if (empty_ext[dest_q]) begin
               state_d = LOAD_FIRST_DATA;
            end else if (wcnt_q == WT_LAST) begin
               state_d = DROP_PACKET;
               expire  = 1'b1;
            end else begin
               wcnt_d = wcnt_q + 16'd1;
            end
         end
         LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         FIFO_FULL_STATE: begin
            if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            if (bus.parity_done)           state_d = DECODE_ADDRESS;
            else if (bus.low_packet_valid) state_d = LOAD_PARITY;
            else                           state_d = LOAD_DATA;
         end
         DROP_PACKET: begin
            if (!bus.pkt_valid) state_d = DECODE_ADDRESS;
         end
         default:            state_d = DECODE_ADDRESS;
      endcase
      // Soft reset of the selected port overrides every transition; the
      // timeout pulse is suppressed since the drop does not happen.
      if (state_q != DECODE_ADDRESS && srst_ext[dest_q]) begin
         state_d = DECODE_ADDRESS;
         wcnt_d  = '0;
         expire  = 1'b0;
      end
   end

   // State, destination and wait-counter registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= DECODE_ADDRESS;
         dest_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         dest_q  <= dest_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Moore state decodes; timeout pulses only when the drop transition will be taken.
   always_comb begin
      bus.detect_add    = (state_q == DECODE_ADDRESS);
      bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
      bus.ld_state      = (state_q == LOAD_DATA);
      bus.laf_state     = (state_q == LOAD_AFTER_FULL);
      bus.full_state    = (state_q == FIFO_FULL_STATE);
      bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
      bus.drop_state    = (state_q == DROP_PACKET);
      bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                          (state_q == LOAD_AFTER_FULL);
      bus.busy          = (state_q == LOAD_FIRST_DATA) || (state_q == WAIT_TILL_EMPTY) ||
                          (state_q == LOAD_PARITY) || (state_q == CHECK_PARITY_ERROR) ||
                          (state_q == FIFO_FULL_STATE) || (state_q == LOAD_AFTER_FULL);
      bus.wait_timeout  = expire & resetn;
      bus.dest_port     = dest_q;
   end

endmodule

// File: tb/tb_router_fsm_np.sv
// Self-checking bench for router_fsm_np: directed scenarios with literal
// expectations, then randomized traffic checked against a named-state model.
module tb_router_fsm_np;
   localparam int NP = 3;
   localparam int AW = 2;
   localparam int WT = 4;

   logic  clock = 1'b0;
   logic  resetn;
   int    total = 0;
   int    bad   = 0;
   int    we_cnt;

   // Reference model: state as a readable name, wait budget as cycles remaining.
   string m_st   = "DA";
   int    m_dest = 0;
   int    m_left = 0;
   bit    m_ok   = 1'b0;

   router_fsm_np_if #(.NUM_PORTS(NP), .ADDR_W(AW)) bus ();

   router_fsm_np #(.NUM_PORTS(NP), .ADDR_W(AW), .WAIT_TIMEOUT(WT)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   // Expected decode vector {da,lfd,ld,laf,ffs,cpe,drop,we,busy} for a named state.
   function automatic logic [8:0] exp_vec(input string s);
      logic we, by;
      we = (s == "LD") || (s == "LP") || (s == "LAF");
      by = (s == "LFD") || (s == "WTE") || (s == "LP") || (s == "CPE") ||
           (s == "FFS") || (s == "LAF");
      exp_vec = {s == "DA", s == "LFD", s == "LD", s == "LAF", s == "FFS",
                 s == "CPE", s == "DROP", we, by};
   endfunction

   function automatic logic [8:0] dut_vec();
      dut_vec = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
                 bus.rst_int_reg, bus.drop_state, bus.write_enb_reg, bus.busy};
   endfunction

   function automatic string dut_name();
      string names [9];
      names = '{"DA", "LFD", "LD", "WTE", "LP", "CPE", "FFS", "LAF", "DROP"};
      dut_name = "???";
      for (int i = 0; i < 9; i++)
         if (dut_vec() == exp_vec(names[i])) dut_name = names[i];
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (model %s) t=%0t", name, got, exp, m_st, $time);
      end
   endtask

   task automatic chk_s(input string name, input string got, input string exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got state %s expected %s t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic step(input string tag, input string exp);
      tick();
      chk_s(tag, dut_name(), exp);
      we_cnt += int'(bus.write_enb_reg);
   endtask

   // Model advance on each rising edge from the inputs presented before it.
   always @(posedge clock) begin : model
      string n;
      int    d, left;
      n = m_st; d = m_dest; left = m_left;
      if (!resetn) begin
         n = "DA"; d = 0; left = 0;
      end else if (m_st != "DA" && m_dest < NP && bus.soft_reset[m_dest]) begin
         n = "DA";
      end else if (m_st == "DA") begin
         if (bus.pkt_valid) begin
            d = int'(bus.data_in);
            if (d >= NP)                  n = "DROP";
            else if (bus.fifo_empty[d])   n = "LFD";
            else begin n = "WTE"; left = WT; end
         end
      end else if (m_st == "LFD") n = "LD";
      else if (m_st == "LD") begin
         if (bus.fifo_full)       n = "FFS";
         else if (!bus.pkt_valid) n = "LP";
      end else if (m_st == "WTE") begin
         if (bus.fifo_empty[m_dest]) n = "LFD";
         else if (left == 1)         n = "DROP";
         else                        left = left - 1;
      end else if (m_st == "LP")  n = "CPE";
      else if (m_st == "CPE")     n = bus.fifo_full ? "FFS" : "DA";
      else if (m_st == "FFS") begin
         if (!bus.fifo_full) n = "LAF";
      end else if (m_st == "LAF") begin
         if (bus.parity_done)           n = "DA";
         else if (bus.low_packet_valid) n = "LP";
         else                           n = "LD";
      end else if (m_st == "DROP") begin
         if (!bus.pkt_valid) n = "DA";
      end
      if (!resetn) m_ok <= 1'b1;
      m_st   <= n;
      m_dest <= d;
      m_left <= left;
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clock) begin
      if (m_ok) begin
         logic exp_to;
         exp_to = resetn && m_st == "WTE" && !bus.fifo_empty[m_dest] && m_left == 1 &&
                  !bus.soft_reset[m_dest];
         chk("model_decodes", int'(dut_vec()), int'(exp_vec(m_st)));
         chk("model_dest", int'(bus.dest_port), m_dest);
         chk("model_timeout", int'(bus.wait_timeout), int'(exp_to));
      end
   end

   initial begin
      resetn               = 1'b0;
      bus.pkt_valid        = 1'b0;
      bus.data_in          = '0;
      bus.fifo_full        = 1'b0;
      bus.fifo_empty       = 3'b111;
      bus.soft_reset       = '0;
      bus.parity_done      = 1'b0;
      bus.low_packet_valid = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      chk_s("reset_state", dut_name(), "DA");
      chk("reset_outs", int'(dut_vec()), 9'h100);
      chk("reset_dest", int'(bus.dest_port), 0);
      chk("reset_timeout", int'(bus.wait_timeout), 0);

      // Normal packet to port 1 with four payload bytes.
      we_cnt = 0;
      bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
      step("pkt_lfd", "LFD"); bus.data_in = 2'd3;
      step("pkt_ld1", "LD");  bus.data_in = 2'd0;
      step("pkt_ld2", "LD");
      step("pkt_ld3", "LD");
      step("pkt_ld4", "LD");  bus.pkt_valid = 1'b0;
      step("pkt_lp", "LP");
      step("pkt_cpe", "CPE");
      step("pkt_da", "DA");
      chk("pkt_we_cycles", we_cnt, 5);
      chk("pkt_dest", int'(bus.dest_port), 1);

      // Address beyond the last port is discarded while the source keeps streaming.
      bus.pkt_valid = 1'b1; bus.data_in = 2'd3;
      step("drop_1", "DROP");
      chk("drop_busy", int'(bus.busy), 0);
      chk("drop_we", int'(bus.write_enb_reg), 0);
      step("drop_2", "DROP");
      bus.pkt_valid = 1'b0;
      step("drop_end", "DA");
      chk("drop_dest", int'(bus.dest_port), 3);

      // Destination never drains: four wait cycles, pulse on the last, then drop.
      bus.fifo_empty = 3'b011; bus.pkt_valid = 1'b1; bus.data_in = 2'd2;
      step("wait_1", "WTE");
      chk("wait_to_1", int'(bus.wait_timeout), 0);
      step("wait_2", "WTE");
      step("wait_3", "WTE");
      chk("wait_to_3", int'(bus.wait_timeout), 0);
      step("wait_4", "WTE");
      chk("wait_to_4", int'(bus.wait_timeout), 1);
      step("wait_drop", "DROP");
      chk("wait_to_after", int'(bus.wait_timeout), 0);
      bus.pkt_valid = 1'b0;
      step("wait_da", "DA");

      // Only the addressed port's empty flag matters.
      bus.fifo_empty = 3'b110; bus.pkt_valid = 1'b1; bus.data_in = 2'd2;
      step("other_empty_lfd", "LFD");
      bus.pkt_valid = 1'b0;
      step("other_empty_ld", "LD");
      step("other_empty_lp", "LP");
      step("other_empty_cpe", "CPE");
      step("other_empty_da", "DA");

      // FIFO full during payload, resume into LD, then into LP via low_packet_valid.
      bus.fifo_empty = 3'b111; bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
      step("full_lfd", "LFD");
      step("full_ld", "LD");   bus.fifo_full = 1'b1;
      step("full_ffs1", "FFS");
      step("full_ffs2", "FFS");
      step("full_ffs3", "FFS"); bus.fifo_full = 1'b0;
      step("full_laf", "LAF");
      step("full_ld_again", "LD"); bus.fifo_full = 1'b1;
      step("full_ffs4", "FFS"); bus.fifo_full = 1'b0; bus.low_packet_valid = 1'b1;
      step("full_laf2", "LAF");
      step("full_lp", "LP");   bus.low_packet_valid = 1'b0; bus.pkt_valid = 1'b0;
      step("full_cpe", "CPE");
      step("full_da", "DA");

      // Soft reset: other port ignored, selected port aborts.
      bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
      step("srst_lfd", "LFD");
      step("srst_ld", "LD");   bus.soft_reset = 3'b001;
      step("srst_other", "LD"); bus.soft_reset = 3'b010;
      step("srst_sel", "DA");  bus.soft_reset = '0; bus.pkt_valid = 1'b0;
      step("srst_idle", "DA");

      // Hard reset in the middle of a full stall.
      bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
      step("hrst_lfd", "LFD");
      step("hrst_ld", "LD");   bus.fifo_full = 1'b1;
      step("hrst_ffs", "FFS"); resetn = 1'b0;
      step("hrst_da", "DA");
      chk("hrst_full_state", int'(bus.full_state), 0);
      chk("hrst_dest", int'(bus.dest_port), 0);
      resetn = 1'b1; bus.fifo_full = 1'b0; bus.pkt_valid = 1'b0;
      tick();

      // Randomized traffic; empty-flag bias switches to also exercise timeouts.
      for (int c = 0; c < 3000; c++) begin
         int unsigned emp_pct;
         emp_pct = ((c / 60) % 2 == 0) ? 70 : 10;
         bus.pkt_valid        = ($urandom_range(0, 3) != 0);
         bus.data_in          = 2'($urandom_range(0, 3));
         bus.fifo_full        = ($urandom_range(0, 6) == 0);
         for (int p = 0; p < NP; p++)
            bus.fifo_empty[p] = ($urandom_range(0, 99) < emp_pct);
         bus.soft_reset       = ($urandom_range(0, 24) == 0) ? 3'($urandom) : '0;
         bus.parity_done      = ($urandom_range(0, 4) == 0);
         bus.low_packet_valid = ($urandom_range(0, 4) == 0);
         resetn               = ($urandom_range(0, 79) != 0);
         tick();
      end
      resetn = 1'b1;
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
